mem_bus_arbiter: RTL

Two-requester arbiter that shares the single DRAM-side memory bus between the instruction cache (port s0) and the data cache (port s1). It grants the bus to one cache at a time and holds that grant until the cache's full transaction completes: an address beat, then 8 read-response beats or 8 write-data beats. It sits between the two `set_cache` instances and the memory model. It forwards the reqcyc/reqack and respcyc/respack handshakes unchanged to and from the granted requester.

---
 rtl/mem_bus_arbiter_pkg.sv | 25 ++
 rtl/mem_bus_arbiter_if.sv | 30 +++
 rtl/mem_bus_arbiter_rr_arbiter2.sv | 20 ++
 rtl/mem_bus_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the DRAM-side memory bus and its arbiter.
// The read/write tag encoding is also used by set_cache.
package mem_bus_pkg;

    localparam int BUS_DATA_WIDTH_DEF = 64;
    localparam int BUS_TAG_WIDTH_DEF  = 13;
    localparam int BEATS_DEF          = 8;
    localparam int TAG_RW_BIT         = BUS_TAG_WIDTH_DEF - 1;

    // Tag MSB: 1 = read request, 0 = write request
    localparam logic TAG_READ  = 1'b1;
    localparam logic TAG_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_e;

    function automatic logic tag_is_read(input logic [BUS_TAG_WIDTH_DEF-1:0] tag);
        return tag[TAG_RW_BIT] == TAG_READ;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One memory-bus link: request channel (reqcyc/reqack) and response channel (respcyc/respack).
// Handshake: a beat transfers on a cycle where cyc and ack are both 1; the driver holds
// data/tag stable while cyc=1 and ack=0, and ack may depend combinationally on cyc.
interface mem_bus_if
    import mem_bus_pkg::*;
#(
    parameter int DW = BUS_DATA_WIDTH_DEF,
    parameter int TW = BUS_TAG_WIDTH_DEF
) ();

    logic          reqcyc;
    logic          reqack;
    logic [DW-1:0] req;
    logic [TW-1:0] reqtag;
    logic          respcyc;
    logic          respack;
    logic [DW-1:0] resp;
    logic [TW-1:0] resptag;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = req[1];
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the DRAM bus between the I-cache (s0) and D-cache (s1), holding the grant
// for a whole transaction: one address beat then BEATS data or response beats.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = BUS_DATA_WIDTH_DEF,
    parameter int BUS_TAG_WIDTH  = BUS_TAG_WIDTH_DEF,
    parameter int BEATS          = BEATS_DEF
) (
    input  logic     clk,
    input  logic     reset,
    mem_bus_if.slave  s0,
    mem_bus_if.slave  s1,
    mem_bus_if.master m,
    output logic     stray_resp,
    output state_e   o_dbg_state
);

    localparam int            CW        = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    state_e              r_state;
    state_e              w_next_state;
    logic                r_owner;
    logic                r_last_grant;
    logic                r_is_read;
    logic [CW-1:0]       r_cnt;

    logic                w_gnt_valid;
    logic                w_gnt_id;
    logic                w_gnt_is_read;
    logic                w_own_reqcyc;
    logic                w_own_respack;
    logic [BUS_DATA_WIDTH-1:0] w_own_req;
    logic [BUS_TAG_WIDTH-1:0]  w_own_reqtag;
    logic                w_req_fire;
    logic                w_resp_fire;
    logic                w_last;

    rr_arbiter2 u_rr (
        .req        ({s1.reqcyc, s0.reqcyc}),
        .last_grant (r_last_grant),
        .gnt_valid  (w_gnt_valid),
        .gnt_id     (w_gnt_id)
    );

    assign w_gnt_is_read = (w_gnt_id ? s1.reqtag[BUS_TAG_WIDTH-1]
                                     : s0.reqtag[BUS_TAG_WIDTH-1]) == TAG_READ;

    assign w_own_reqcyc  = r_owner ? s1.reqcyc  : s0.reqcyc;
    assign w_own_req     = r_owner ? s1.req     : s0.req;
    assign w_own_reqtag  = r_owner ? s1.reqtag  : s0.reqtag;
    assign w_own_respack = r_owner ? s1.respack : s0.respack;

    // Fire terms are only consulted in the states where their channel is forwarded
    assign w_req_fire  = w_own_reqcyc & m.reqack;
    assign w_resp_fire = m.respcyc & w_own_respack;
    assign w_last      = (r_cnt == LAST_BEAT);

    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_gnt_valid)            w_next_state = ADDR;
            ADDR:    if (w_req_fire)             w_next_state = r_is_read ? RDATA : WDATA;
            WDATA:   if (w_req_fire && w_last)   w_next_state = IDLE;
            RDATA:   if (w_resp_fire && w_last)  w_next_state = IDLE;
            default:                             w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_is_read    <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_gnt_valid) begin
                        r_owner      <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                        r_is_read    <= w_gnt_is_read;
                    end
                end
                WDATA: if (w_req_fire)  r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                RDATA: if (w_resp_fire) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        m.reqcyc   = 1'b0;
        m.req      = '0;
        m.reqtag   = '0;
        m.respack  = 1'b0;
        s0.reqack  = 1'b0;
        s0.respcyc = 1'b0;
        s0.resp    = '0;
        s0.resptag = '0;
        s1.reqack  = 1'b0;
        s1.respcyc = 1'b0;
        s1.resp    = '0;
        s1.resptag = '0;
        case (r_state)
            ADDR, WDATA: begin
                m.reqcyc = w_own_reqcyc;
                m.req    = w_own_req;
                m.reqtag = w_own_reqtag;
                if (r_owner) s1.reqack = m.reqack;
                else         s0.reqack = m.reqack;
            end
            RDATA: begin
                m.respack = w_own_respack;
                if (r_owner) begin
                    s1.respcyc = m.respcyc;
                    s1.resp    = m.resp;
                    s1.resptag = m.resptag;
                end else begin
                    s0.respcyc = m.respcyc;
                    s0.resp    = m.resp;
                    s0.resptag = m.resptag;
                end
            end
            default: ;
        endcase
        // Gated by reset so every output is low while reset is held
        stray_resp = reset && m.respcyc && (r_state != RDATA);
    end

endmodule
